// File: rtl/nios_ii_system_lcd_sequencer_if.sv
// Avalon-MM bus between the Nios II data master and the LCD sequencer slave.
interface nios_ii_system_lcd_sequencer_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/nios_ii_system_lcd_sequencer.sv
// Avalon-MM slave that stretches CPU accesses into timed HD44780 bus cycles and stalls until a write is executed.
// Build option LCD_SEQ_BUSY_POLL_EN: poll the LCD busy flag after each write instead of a fixed settle delay.
module nios_ii_system_lcd_sequencer #(
  parameter int SETUP_CYC  = 3,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 2,
  parameter int WAIT_CYC   = 2000,
  parameter int POLL_LIMIT = 4095
) (
  input  logic                          clk,
  input  logic                          reset,
  nios_ii_system_lcd_sequencer_if.slave avs,
  output logic                          LCD_E,
  output logic                          LCD_RS,
  output logic                          LCD_RW,
  inout  wire  [7:0]                    LCD_data
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0, SETUP  = 4'd1, EHIGH = 4'd2, HOLD = 4'd3, WAIT = 4'd4,
    PSETUP = 4'd5, PEHIGH = 4'd6, PHOLD = 4'd7, DONE = 4'd8
  } state_t;

  localparam int PHASE_MAX = (E_HIGH_CYC > SETUP_CYC)
                             ? ((E_HIGH_CYC > HOLD_CYC) ? E_HIGH_CYC : HOLD_CYC)
                             : ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
`ifdef LCD_SEQ_BUSY_POLL_EN
  localparam int CNT_MAX = PHASE_MAX;
  localparam int POLL_W  = $clog2(POLL_LIMIT + 1);
`else
  localparam int CNT_MAX = (WAIT_CYC > PHASE_MAX) ? WAIT_CYC : PHASE_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  if (SETUP_CYC < 1 || E_HIGH_CYC < 1 || HOLD_CYC < 1 || WAIT_CYC < 1 || POLL_LIMIT < 1) begin : g_bad_params
    $error("nios_ii_system_lcd_sequencer: timing parameters must all be at least 1");
  end

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             rs_r, rs_s, rw_r, rw_s;
  logic [7:0]       data_r, data_s;
  logic [7:0]       readdata_r;
  logic             e_r, e_s, lcd_rs_r, lcd_rs_s, lcd_rw_r, lcd_rw_s, oe_r, oe_s;
  logic             cnt_zero_s;
`ifdef LCD_SEQ_BUSY_POLL_EN
  logic [POLL_W-1:0] poll_r, poll_s;
  logic              busy_r, busy_s;
`endif

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Next state, phase counter and request latch.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rs_s    = rs_r;
    rw_s    = rw_r;
    data_s  = data_r;
`ifdef LCD_SEQ_BUSY_POLL_EN
    poll_s  = poll_r;
    busy_s  = busy_r;
`endif
    case (state_r)
      IDLE: begin
        if (avs.read || avs.write) begin
          rs_s    = avs.address[1];
          rw_s    = (avs.read && avs.write) ? 1'b0 : avs.address[0];
          data_s  = avs.writedata;
          cnt_s   = CNT_W'(SETUP_CYC - 1);
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_zero_s) begin
          state_s = EHIGH;
          cnt_s   = CNT_W'(E_HIGH_CYC - 1);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      EHIGH: begin
        if (cnt_zero_s) begin
          state_s = HOLD;
          cnt_s   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!cnt_zero_s) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (rw_r) begin
          state_s = DONE;
        end else begin
`ifdef LCD_SEQ_BUSY_POLL_EN
          state_s = PSETUP;
          cnt_s   = CNT_W'(SETUP_CYC - 1);
          poll_s  = {POLL_W{1'b0}};
`else
          state_s = WAIT;
          cnt_s   = CNT_W'(WAIT_CYC - 1);
`endif
        end
      end
`ifdef LCD_SEQ_BUSY_POLL_EN
      PSETUP: begin
        if (cnt_zero_s) begin
          state_s = PEHIGH;
          cnt_s   = CNT_W'(E_HIGH_CYC - 1);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      PEHIGH: begin
        if (cnt_zero_s) begin
          state_s = PHOLD;
          cnt_s   = CNT_W'(HOLD_CYC - 1);
          busy_s  = LCD_data[7];
          poll_s  = poll_r + POLL_W'(1);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      PHOLD: begin
        if (!cnt_zero_s) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (busy_r && (poll_r < POLL_W'(POLL_LIMIT))) begin
          state_s = PSETUP;
          cnt_s   = CNT_W'(SETUP_CYC - 1);
        end else begin
          state_s = DONE;
        end
      end
`else
      WAIT: begin
        if (cnt_zero_s) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
`endif
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Pin values for the upcoming state; registered so the LCD pins never glitch.
  always_comb begin
    e_s      = 1'b0;
    lcd_rs_s = 1'b0;
    lcd_rw_s = 1'b1;
    oe_s     = 1'b0;
    case (state_s)
      SETUP, HOLD: begin
        lcd_rs_s = rs_s;
        lcd_rw_s = rw_s;
        oe_s     = ~rw_s;
      end
      EHIGH: begin
        e_s      = 1'b1;
        lcd_rs_s = rs_s;
        lcd_rw_s = rw_s;
        oe_s     = ~rw_s;
      end
`ifdef LCD_SEQ_BUSY_POLL_EN
      PEHIGH:  e_s = 1'b1;
`endif
      default: e_s = 1'b0;
    endcase
  end

  // Sequencer state, request latch and LCD pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      rs_r     <= 1'b0;
      rw_r     <= 1'b1;
      data_r   <= 8'h00;
      e_r      <= 1'b0;
      lcd_rs_r <= 1'b0;
      lcd_rw_r <= 1'b1;
      oe_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rs_r     <= rs_s;
      rw_r     <= rw_s;
      data_r   <= data_s;
      e_r      <= e_s;
      lcd_rs_r <= lcd_rs_s;
      lcd_rw_r <= lcd_rw_s;
      oe_r     <= oe_s;
    end
  end

  // Read data is taken on the last enable-high cycle of a read bus cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= 8'h00;
    end else if (state_r == EHIGH && cnt_zero_s && rw_r) begin
      readdata_r <= LCD_data;
    end else begin
      readdata_r <= readdata_r;
    end
  end

`ifdef LCD_SEQ_BUSY_POLL_EN
  // Busy-flag poll bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_r <= {POLL_W{1'b0}};
      busy_r <= 1'b0;
    end else begin
      poll_r <= poll_s;
      busy_r <= busy_s;
    end
  end
`endif

  assign LCD_E           = e_r;
  assign LCD_RS          = lcd_rs_r;
  assign LCD_RW          = lcd_rw_r;
  assign LCD_data        = oe_r ? data_r : 8'bzzzz_zzzz;
  assign avs.readdata    = readdata_r;
  assign avs.waitrequest = (avs.read | avs.write) & (state_r != DONE);

endmodule

// File: tb/tb_nios_ii_system_lcd_sequencer.sv
// Self-checking bench for nios_ii_system_lcd_sequencer: directed table, hand sequences and random accesses.
// Checks against a latency/pin model derived from the bus-cycle timing rules; honours LCD_SEQ_BUSY_POLL_EN.
module tb_nios_ii_system_lcd_sequencer;
  localparam int SETUP_CYC   = 3;
  localparam int E_HIGH_CYC  = 12;
  localparam int HOLD_CYC    = 2;
  localparam int WAIT_CYC    = 2000;
  localparam int POLL_LIMIT  = 8;
  localparam int STALL_LIMIT = 2100;
`ifdef LCD_SEQ_BUSY_POLL_EN
  localparam int WS = 35;
  localparam int WR = 2;
`else
  localparam int WS = 2018;
  localparam int WR = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lcd_e, lcd_rs, lcd_rw;
  wire  [7:0] lcd_bus;
  logic [7:0] drv_val;

  nios_ii_system_lcd_sequencer_if bus ();

  nios_ii_system_lcd_sequencer #(
    .SETUP_CYC(SETUP_CYC), .E_HIGH_CYC(E_HIGH_CYC), .HOLD_CYC(HOLD_CYC),
    .WAIT_CYC(WAIT_CYC), .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_data(lcd_bus)
  );

  // LCD model: drives the bus whenever the sequencer selects read direction.
  int         busy_left = 0;
  bit         poll_phase = 1'b0;
  logic [7:0] model_val = 8'h00;
  assign drv_val = poll_phase ? {(busy_left > 0), 7'h00} : model_val;
  assign lcd_bus = lcd_rw ? drv_val : 8'bzzzz_zzzz;

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expectations for the data-phase pins and the E-pulse monitor results.
  bit         exp_rs, exp_rw;
  logic [7:0] exp_wd;
  int mon_runs = 0, mon_len_bad = 0, mon_pin_bad = 0, mon_gap_bad = 0;
  int cyc = 0, last_fall = -1000, run_len = 0;
  bit e_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (lcd_e) begin
      if (!e_prev) begin
        mon_runs = mon_runs + 1;
        if (cyc - last_fall < HOLD_CYC) mon_gap_bad = mon_gap_bad + 1;
        run_len = 0;
      end
      run_len = run_len + 1;
      if (mon_runs == 1) begin
        if (lcd_rs !== exp_rs || lcd_rw !== exp_rw || lcd_bus !== (exp_rw ? model_val : exp_wd))
          mon_pin_bad = mon_pin_bad + 1;
      end else if (lcd_rs !== 1'b0 || lcd_rw !== 1'b1) begin
        mon_pin_bad = mon_pin_bad + 1;
      end
    end else if (e_prev) begin
      if (run_len != E_HIGH_CYC) mon_len_bad = mon_len_bad + 1;
      last_fall = cyc;
      if (mon_runs == 1 && !exp_rw) poll_phase = 1'b1;
      else if (mon_runs > 1 && busy_left > 0) busy_left = busy_left - 1;
    end
    e_prev = lcd_e;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: stall count and number of E pulses from the bus-cycle rules.
  function automatic int n_polls(input int busy);
    return (busy + 1 > POLL_LIMIT) ? POLL_LIMIT : busy + 1;
  endfunction

  function automatic int model_stall(input bit rw, input int busy);
    int base;
    base = 1 + SETUP_CYC + E_HIGH_CYC + HOLD_CYC;
    if (rw) return base;
`ifdef LCD_SEQ_BUSY_POLL_EN
    return base + n_polls(busy) * (SETUP_CYC + E_HIGH_CYC + HOLD_CYC);
`else
    return base + WAIT_CYC + 0 * busy;
`endif
  endfunction

  function automatic int model_runs(input bit rw, input int busy);
    if (rw) return 1;
`ifdef LCD_SEQ_BUSY_POLL_EN
    return 1 + n_polls(busy);
`else
    return 1 + 0 * busy;
`endif
  endfunction

  // Called at posedge+1 in IDLE: present a request and arm the monitor.
  task automatic xfer_begin(input bit rd, input bit wr, input logic [1:0] a, input logic [7:0] wd,
                            input logic [7:0] mv, input int busy, input bit ers, input bit erw);
    mon_runs = 0; mon_len_bad = 0; mon_pin_bad = 0; mon_gap_bad = 0;
    poll_phase = 1'b0; busy_left = busy; model_val = mv;
    exp_rs = ers; exp_rw = erw; exp_wd = wd;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
  endtask

  task automatic xfer_wait(input string name, input int estall, input int eruns, input logic [7:0] erd);
    int stall;
    stall = 0;
    #1;
    while (bus.waitrequest && stall < STALL_LIMIT) begin
      stall++;
      @(posedge clk); #1;
    end
    chk({name, "_stall"}, stall, estall);
    chk({name, "_readdata"}, int'(bus.readdata), int'(erd));
    chk({name, "_e_pulses"}, mon_runs, eruns);
    chk({name, "_e_width_pins_gap"}, mon_len_bad + mon_pin_bad + mon_gap_bad, 0);
  endtask

  task automatic xfer_end(input string name);
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    #1;
    chk({name, "_idle_pins"}, int'({lcd_e, lcd_rs, lcd_rw}), 1);
    chk({name, "_idle_bus"}, int'(lcd_bus), int'(drv_val));
  endtask

  typedef struct {
    bit rd; bit wr; logic [1:0] a; logic [7:0] wd; logic [7:0] lv;
    bit ers; bit erw; int estall; int eruns; logic [7:0] erd;
  } vec_t;
  vec_t tbl [6];
  logic [7:0] m_rdata;

  initial begin
    int seen;
    bit rd, wr, rw_m;
    logic [1:0] a;
    logic [7:0] wd, mv;
    int bz, k;

    tbl[0] = '{1'b0, 1'b1, 2'd0, 8'h38, 8'h11, 1'b0, 1'b0, WS, WR, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 2'd3, 8'h5A, 8'hA5, 1'b1, 1'b1, 18, 1, 8'hA5};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 8'hFF, 8'h3C, 1'b0, 1'b1, 18, 1, 8'h3C};
    tbl[3] = '{1'b0, 1'b1, 2'd2, 8'h48, 8'h00, 1'b1, 1'b0, WS, WR, 8'h3C};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 8'h77, 8'h81, 1'b1, 1'b1, 18, 1, 8'h81};
    tbl[5] = '{1'b1, 1'b1, 2'd1, 8'h66, 8'h99, 1'b0, 1'b0, WS, WR, 8'h81};

    bus.read = 1'b0; bus.write = 1'b0; bus.address = 2'd0; bus.writedata = 8'h00;
    model_val = 8'hC4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_pins", int'({lcd_e, lcd_rs, lcd_rw}), 1);
    chk("rst_bus_released", int'(lcd_bus), 8'hC4);
    chk("rst_readdata", int'(bus.readdata), 0);
    chk("rst_waitrequest", int'(bus.waitrequest), 0);

    // Reset asserted in the middle of the enable pulse of a write.
    @(posedge clk); #1;
    xfer_begin(1'b0, 1'b1, 2'd0, 8'h38, 8'hC4, 0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(posedge clk); #1;
      if (lcd_e) seen++;
    end
    chk("abort_reached_ehigh", seen, 3);
    reset = 1'b1; bus.write = 1'b0;
    #1;
    chk("abort_pins", int'({lcd_e, lcd_rw}), 1);
    chk("abort_bus_released", int'(lcd_bus), 8'hC4);
    chk("abort_waitrequest", int'(bus.waitrequest), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    xfer_begin(1'b0, 1'b1, 2'd0, 8'h38, 8'hC4, 0, 1'b0, 1'b0);
    xfer_wait("after_abort_w38", WS, WR, 8'h00);
    xfer_end("after_abort_w38");

    for (int i = 0; i < 6; i++) begin
      xfer_begin(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].lv, 0, tbl[i].ers, tbl[i].erw);
      xfer_wait($sformatf("vec%0d", i), tbl[i].estall, tbl[i].eruns, tbl[i].erd);
      xfer_end($sformatf("vec%0d", i));
    end
    m_rdata = 8'h81;

`ifdef LCD_SEQ_BUSY_POLL_EN
    xfer_begin(1'b0, 1'b1, 2'd0, 8'h01, 8'h00, 3, 1'b0, 1'b0);
    xfer_wait("poll_busy3", 86, 5, m_rdata);
    xfer_end("poll_busy3");
    xfer_begin(1'b0, 1'b1, 2'd0, 8'h02, 8'h00, 100000, 1'b0, 1'b0);
    xfer_wait("poll_stuck", 18 + POLL_LIMIT * 17, 1 + POLL_LIMIT, m_rdata);
    xfer_end("poll_stuck");
    xfer_begin(1'b1, 1'b0, 2'd1, 8'h00, 8'h5E, 0, 1'b0, 1'b1);
    xfer_wait("after_stuck_read", 18, 1, 8'h5E);
    xfer_end("after_stuck_read");
    m_rdata = 8'h5E;
`endif

    // Back-to-back writes with write held high through DONE.
    xfer_begin(1'b0, 1'b1, 2'd2, 8'h41, 8'h00, 0, 1'b1, 1'b0);
    xfer_wait("b2b_w41", WS, WR, m_rdata);
    @(posedge clk); #1;
    xfer_begin(1'b0, 1'b1, 2'd2, 8'h42, 8'h00, 0, 1'b1, 1'b0);
    xfer_wait("b2b_w42", WS, WR, m_rdata);
    xfer_end("b2b_w42");

    for (int i = 0; i < 12; i++) begin
      k  = int'($urandom_range(2, 0));
      rd = (k != 1);
      wr = (k != 0);
      a  = 2'($urandom_range(3, 0));
      wd = 8'($urandom_range(255, 0));
      mv = 8'($urandom_range(255, 0));
      bz = int'($urandom_range(10, 0));
      rw_m = (rd && wr) ? 1'b0 : a[0];
      if (rw_m) m_rdata = mv;
      xfer_begin(rd, wr, a, wd, mv, bz, a[1], rw_m);
      xfer_wait($sformatf("rand%0d", i), model_stall(rw_m, bz), model_runs(rw_m, bz), m_rdata);
      xfer_end($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nios_ii_system_lcd_sequencer.md
# nios_ii_system_lcd_sequencer

- Avalon-MM slave that sits between the Nios II data master and the 8-bit HD44780-class character LCD.
- Stretches each CPU access into a correctly timed LCD bus cycle: address setup, enable pulse, hold.
- After a write, stalls the CPU until the display has finished executing the command or data byte, so software never busy-waits.

## Interface
Parameters:
- SETUP_CYC, 3: clocks of RS/RW/data setup before E rises (≥40 ns at 50 MHz).
- E_HIGH_CYC, 12: clocks LCD_E is high (≥230 ns).
- HOLD_CYC, 2: clocks RS/RW/data held after E falls.
- WAIT_CYC, 2000: post-write settle clocks (40 µs) when busy polling is compiled out.
- POLL_LIMIT, 4095: maximum busy-flag polls per write.

Ports:
- clk, in, 1: system clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- address, in, 2: bit0 = RW (1 = read), bit1 = RS.
- read, in, 1: Avalon read strobe.
- write, in, 1: Avalon write strobe.
- writedata, in, 8: byte to send.
- readdata, out, 8: byte captured from the LCD.
- waitrequest, out, 1: Avalon stall.
- LCD_E, out, 1: enable strobe.
- LCD_RS, out, 1: register select.
- LCD_RW, out, 1: read/write select.
- LCD_data, inout, 8: bidirectional data bus.

## Operation
- States: IDLE, SETUP, EHIGH, HOLD, WAIT, PSETUP, PEHIGH, PHOLD, DONE. One down-counter, width covers max(WAIT_CYC, E_HIGH_CYC).
- IDLE
  - On read|write, latch rs = address[1], rw = address[0], data = writedata, and go to SETUP.
  - write with address[0]=1 is treated as a read; read and write together: write wins with rw forced to 0.
- SETUP for SETUP_CYC cycles with E=0, then EHIGH for E_HIGH_CYC cycles with E=1, then HOLD for HOLD_CYC cycles with E=0.
- HOLD exit:
  - rw=1 (read): go to DONE.
  - rw=0 (write): go to WAIT, or to PSETUP when busy polling is enabled.
- Read capture: readdata <= LCD_data on the last EHIGH cycle; it holds until the next read capture.
- Drive rules:
  - LCD_RS = rs and LCD_RW = rw from SETUP through HOLD.
  - LCD_data = data only when rw=0 in SETUP, EHIGH and HOLD; otherwise high-Z.
  - In IDLE, WAIT and DONE: LCD_RW=1, LCD_RS=0, E=0.
- WAIT: count WAIT_CYC cycles, then go to DONE.
- Poll sub-cycle (PSETUP, PEHIGH, PHOLD): same timings as SETUP/EHIGH/HOLD with RS=0, RW=1, bus high-Z.
  - LCD_data[7] is sampled on the last PEHIGH cycle. This poll data is not written to readdata.
  - Busy=1 and polls < POLL_LIMIT: go back to PSETUP.
  - Busy=0, or POLL_LIMIT reached: go to DONE.
- DONE: one cycle, waitrequest=0, then IDLE. A request arriving in DONE is not accepted until IDLE.

## Timing
- Reset values: state IDLE, LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data high-Z, readdata=0x00, waitrequest=0, counters 0.
- Reset asserted mid-transfer: E drops and the bus releases asynchronously. The aborted access is not completed.
- waitrequest = (read|write) & (state != DONE). It is combinational, so it is high in the accept cycle.
- The master holds address, writedata and strobes stable while waitrequest=1.
- Read latency, strobe to waitrequest low: 1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC cycles. Defaults give 18 stalled cycles, completing on cycle 19.
- Write latency without polling: 18 + WAIT_CYC stalled cycles (2018 at defaults).
- Write latency with polling: 18 + n·(SETUP_CYC+E_HIGH_CYC+HOLD_CYC) stalled cycles, where n is the number of polls, 1 ≤ n ≤ POLL_LIMIT.
- LCD_E is high for exactly E_HIGH_CYC consecutive cycles per bus cycle. It is never high in IDLE, WAIT or DONE.

## Configuration
- LCD_SEQ_BUSY_POLL_EN defined:
  - After each write, poll the busy flag.
  - WAIT is unreachable and the WAIT_CYC counter is not synthesized.
- LCD_SEQ_BUSY_POLL_EN undefined:
  - After each write, fixed WAIT_CYC delay.
  - PSETUP/PEHIGH/PHOLD and POLL_LIMIT logic are not synthesized.

## Test plan
- Reset check: pulse reset mid-EHIGH → LCD_E=0, LCD_RW=1, bus Z, waitrequest=0 immediately; next write 0x38 completes normally.
- Write 0x38 to address 0 (no poll build):
  - LCD_RS=0, LCD_RW=0, data 0x38 from SETUP through HOLD.
  - E high exactly 12 cycles.
  - waitrequest low on cycle 2019.
- Read address 3 with model driving 0xA5:
  - RS=1, RW=1, bus not driven by DUT.
  - readdata=0xA5 when waitrequest falls on cycle 19.
- Poll build, model busy for 3 polls then 0: write 0x01 completes after 4 polls = 18+4·17 = 86 stalled cycles.
- Poll build, model stuck busy: completes after POLL_LIMIT polls, waitrequest drops, next request accepted.
- Back-to-back writes 0x41 then 0x42: the second is accepted only in the IDLE after DONE; E pulses never overlap, and ≥HOLD_CYC cycles separate them.
